itch_msg_serializer: RTL
========================

Name: itch_msg_serializer

Overview:
- Encodes book-level order events into an ITCH 5.0 big-endian byte stream, one byte per clock.
- Its output has the same byte-stream format that our ITCH parser consumes.
- Used as the loopback and stimulus source for the parser and the book builder, and as the payload generator for the UDP transmit path.
- Fields are accepted through a valid/ready handshake and streamed out with a data-valid and last-byte marker.

Parameters:
- STOCK, 64'h4141504C20202020 ("AAPL    "), 8-byte ASCII stock field for Add Order messages.
- IDLE_GAP, 0, number of idle cycles forced between the last byte of one message and the first byte of the next (range 0-15).
- TRACKING, 16'h0000, constant tracking-number field placed in every message.

Ports:
- clkIn  input  1  system clock
- rstIn  input  1  synchronous active-high reset
- msgValidIn  input  1  message fields valid
- msgReadyOut  output  1  serializer can accept a message
- msgTypeIn  input  2  0=Add 'A', 1=Executed 'E', 2=Cancel 'X', 3=Delete 'D'
- locateIn  input  16  stock locate
- timestampIn  input  48  nanoseconds since midnight
- orderRefIn  input  64  order reference number
- buySellIn  input  1  1='B', 0='S' (used only by Add)
- sharesIn  input  32  shares, executed shares, or cancelled shares
- priceIn  input  32  price, 4 implied decimals (used only by Add)
- dataOut  output  8  serialized byte
- dataValidOut  output  1  dataOut valid
- lastOut  output  1  final byte of the current message

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - dataOut=0, dataValidOut=0, lastOut=0.
  - msgReadyOut=0 during reset; it is 1 in the first cycle after rstIn deasserts.
  - Match counter = 1; state = IDLE.
- Handshake:
  - A message is accepted on a cycle where msgValidIn && msgReadyOut.
  - All input fields are captured into registers on that edge.
  - The inputs are don't-care on any other cycle.
- msgReadyOut is high when:
  - state is IDLE, or
  - state is SEND on the last byte with IDLE_GAP==0, which allows zero-gap back-to-back messages.
- Latency: the first byte (the type character) appears on dataOut with dataValidOut=1 exactly one cycle after the accept edge.
- States:
  - IDLE: waits for accept. Goes to LEN when MOLD_LEN_PREFIX_EN is defined, otherwise to SEND.
  - LEN: emits the 2 length bytes (MSB first), then goes to SEND.
  - SEND: emits bytes 0..N-1. On byte N-1, asserts lastOut, then goes to:
    - GAP if IDLE_GAP>0;
    - SEND (or LEN) if a new message is accepted that cycle;
    - IDLE otherwise.
  - GAP: holds dataValidOut=0 for IDLE_GAP cycles, then goes to IDLE.
- Byte layouts (all multi-byte fields big-endian):
  - Common header, bytes 0-10: type char, locate(2), TRACKING(2), timestamp(6).
  - 'A' (N=36): header, orderRef(8), 'B'/'S'(1), shares(4), STOCK(8), price(4).
  - 'E' (N=31): header, orderRef(8), shares(4), match number(8).
  - 'X' (N=23): header, orderRef(8), shares(4).
  - 'D' (N=19): header, orderRef(8).
- Byte counter: 6 bits; resets to 0 at the start of each message. The output byte is selected from the captured registers by message type and counter.
- Match counter: 64-bit.
  - Each 'E' message carries the current value.
  - The counter increments on that message's last byte.
  - It wraps from 2^64-1 to 0 with no flag.
- lastOut is high only together with dataValidOut, on byte N-1. It is never high on length-prefix bytes.
- When dataValidOut=0, dataOut is driven to 0.
- Reset mid-message: on the next edge dataValidOut and lastOut go to 0, the captured message is discarded (no partial resume), and the match counter returns to 1.
- msgValidIn held high during SEND/GAP has no effect until msgReadyOut rises.

Optional Feature:
- Macro: ITCH_MOLD_LEN_PREFIX_EN.
- Defined: each message is preceded by a 2-byte big-endian MoldUDP64 message-length field, equal to N (36/31/23/19).
  - The first length byte appears 1 cycle after accept.
  - Total output length per message becomes N+2 bytes.
- Undefined: no LEN state; the type byte follows accept directly, as specified above.

Test Plan:
- Add: type=0, locate=0x0007, ts=0x000102030405, ref=0x11, buy=1, shares=100, price=1_500_000 -> 36 contiguous bytes starting 0x41 00 07 00 00 00 01 02 03 04 05.
  - Byte 19 = 0x42; bytes 20-23 = 00 00 00 64; bytes 32-35 = 00 16 E3 60.
  - lastOut high only on byte 35; first byte 1 cycle after accept.
- Two consecutive Executed, shares=50 -> 31 bytes each; match field = 1 in the first message, then 2; byte 0 = 0x45.
- Back-to-back Cancel then Delete, IDLE_GAP=0, msgValidIn held high -> 23+19 bytes with no dataValidOut gap; msgReadyOut high on byte 22 and in IDLE only.
- IDLE_GAP=3, two Delete messages -> exactly 3 cycles with dataValidOut=0 between the lastOut byte and the next 0x44.
- rstIn asserted at byte 10 of an Add -> dataValidOut=0 on the next edge; the next accepted Delete emits a clean 19-byte message.
- ITCH_MOLD_LEN_PREFIX_EN defined, Add -> bytes 00 24 then 0x41; 38 bytes total; lastOut on the 38th byte.

Source files
------------

// File: rtl/itch_msg_serializer.sv
// itch_msg_serializer: ITCH 5.0 order-event serializer, one big-endian byte per clock (optional MoldUDP64 length prefix: ITCH_MOLD_LEN_PREFIX_EN)
module itch_msg_serializer #(
   parameter logic [63:0] STOCK = 64'h4141504C20202020,
   parameter int IDLE_GAP = 0,
   parameter logic [15:0] TRACKING = 16'h0000
) (
   input logic clkIn,
   input logic rstIn,
   input logic msgValidIn,
   output logic msgReadyOut,
   input logic [1:0] msgTypeIn,
   input logic [15:0] locateIn,
   input logic [47:0] timestampIn,
   input logic [63:0] orderRefIn,
   input logic buySellIn,
   input logic [31:0] sharesIn,
   input logic [31:0] priceIn,
   output logic [7:0] dataOut,
   output logic dataValidOut,
   output logic lastOut
);
   typedef enum logic [1:0] {IDLE, LEN, SEND, GAP} stateType;
   stateType state;
   logic [5:0] cnt;
   logic [3:0] gapCnt;
   logic [1:0] typeR;
   logic [15:0] locR;
   logic [47:0] tsR;
   logic [63:0] refR;
   logic sideR;
   logic [31:0] sharesR;
   logic [31:0] priceR;
   logic [63:0] matchR;
   logic [87:0] header;
   logic [287:0] frame;
   logic [5:0] lastIdx;
   logic [5:0] nextIdx;
   logic [7:0] nextByte;
   logic lastByte;
   logic accept;

   function automatic logic [7:0] typeChar(input logic [1:0] t);
      return (t == 2'd0) ? 8'h41 : (t == 2'd1) ? 8'h45 : (t == 2'd2) ? 8'h58 : 8'h44;
   endfunction

   function automatic logic [5:0] msgLen(input logic [1:0] t);
      return (t == 2'd0) ? 6'd36 : (t == 2'd1) ? 6'd31 : (t == 2'd2) ? 6'd23 : 6'd19;
   endfunction

   // whole message left-aligned in a 36-byte frame; the byte counter walks it from the top
   always_comb begin
      header = {typeChar(typeR), locR, TRACKING, tsR};
      frame = (typeR == 2'd0) ? {header, refR, sideR ? 8'h42 : 8'h53, sharesR, STOCK, priceR}
            : (typeR == 2'd1) ? {header, refR, sharesR, matchR, 40'd0}
            : (typeR == 2'd2) ? {header, refR, sharesR, 104'd0}
            : {header, refR, 136'd0};
      lastIdx = msgLen(typeR) - 6'd1;
      nextIdx = cnt + 6'd1;
      nextByte = frame[{6'd35 - nextIdx, 3'b000} +: 8];
      lastByte = (state == SEND) && (cnt == lastIdx);
   end

   assign msgReadyOut = !rstIn && ((state == IDLE) || (lastByte && (IDLE_GAP == 0)));
   assign accept = msgValidIn && msgReadyOut;

   // message capture, byte sequencing and registered stream outputs
   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         state <= IDLE;
         cnt <= '0;
         gapCnt <= '0;
         typeR <= '0;
         locR <= '0;
         tsR <= '0;
         refR <= '0;
         sideR <= 1'b0;
         sharesR <= '0;
         priceR <= '0;
         matchR <= 64'd1;
         dataOut <= '0;
         dataValidOut <= 1'b0;
         lastOut <= 1'b0;
      end else begin
         if (lastByte && (typeR == 2'd1)) matchR <= matchR + 64'd1;
         if (accept) begin
            typeR <= msgTypeIn;
            locR <= locateIn;
            tsR <= timestampIn;
            refR <= orderRefIn;
            sideR <= buySellIn;
            sharesR <= sharesIn;
            priceR <= priceIn;
            cnt <= '0;
            dataValidOut <= 1'b1;
            lastOut <= 1'b0;
`ifdef ITCH_MOLD_LEN_PREFIX_EN
            state <= LEN;
            dataOut <= 8'h00;
`else
            state <= SEND;
            dataOut <= typeChar(msgTypeIn);
`endif
         end else begin
            case (state)
`ifdef ITCH_MOLD_LEN_PREFIX_EN
               LEN: begin
                  cnt <= (cnt == 6'd0) ? 6'd1 : 6'd0;
                  state <= (cnt == 6'd0) ? LEN : SEND;
                  dataOut <= (cnt == 6'd0) ? {2'b00, msgLen(typeR)} : frame[287:280];
                  dataValidOut <= 1'b1;
                  lastOut <= 1'b0;
               end
`endif
               SEND: begin
                  cnt <= lastByte ? 6'd0 : nextIdx;
                  dataOut <= lastByte ? 8'h00 : nextByte;
                  dataValidOut <= !lastByte;
                  lastOut <= !lastByte && (nextIdx == lastIdx);
                  state <= !lastByte ? SEND : (IDLE_GAP > 1) ? GAP : IDLE;
                  gapCnt <= 4'(IDLE_GAP - 2);
               end
               GAP: begin
                  state <= (gapCnt == 4'd0) ? IDLE : GAP;
                  gapCnt <= gapCnt - 4'd1;
                  dataOut <= '0;
                  dataValidOut <= 1'b0;
                  lastOut <= 1'b0;
               end
               default: begin
                  dataOut <= '0;
                  dataValidOut <= 1'b0;
                  lastOut <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule
